// File: rtl/cndm_proto_pcie_us_msi.sv
// rtl/cndm_proto_pcie_us_msi.sv - MSI generator for the UltraScale PCIe cfg interrupt port
// Folds per-vector requests onto the granted vector count and issues one masked-aware MSI at a time.
module cndm_proto_pcie_us_msi #(
  parameter int IRQ_W       = 32,
  parameter int RETRY_DELAY = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IRQ_W-1:0] irq_req,
  output logic [IRQ_W-1:0] irq_pending,
  input  logic [3:0]       cfg_interrupt_msi_enable,
  input  logic [11:0]      cfg_interrupt_msi_mmenable,
  input  logic             cfg_interrupt_msi_mask_update,
  input  logic [31:0]      cfg_interrupt_msi_data,
  output logic [1:0]       cfg_interrupt_msi_select,
  output logic [31:0]      cfg_interrupt_msi_int,
  output logic [31:0]      cfg_interrupt_msi_pending_status,
  output logic             cfg_interrupt_msi_pending_status_data_enable,
  output logic [1:0]       cfg_interrupt_msi_pending_status_function_num,
  input  logic             cfg_interrupt_msi_sent,
  input  logic             cfg_interrupt_msi_fail,
  output logic [2:0]       cfg_interrupt_msi_attr,
  output logic             cfg_interrupt_msi_tph_present,
  output logic [1:0]       cfg_interrupt_msi_tph_type,
  output logic [7:0]       cfg_interrupt_msi_tph_st_tag,
  output logic [7:0]       cfg_interrupt_msi_function_number
);

  localparam int CW = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY) : 1;
  localparam logic [CW-1:0] LP_CNT_INIT = CW'(RETRY_DELAY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_BACKOFF} state_t;

  state_t         r_state;
  logic [4:0]     r_vec;
  logic [4:0]     r_ptr;
  logic [CW-1:0]  r_cnt;
  logic [31:0]    r_msi_int;
  logic [31:0]    r_pending;
  logic [31:0]    r_mask;
  logic           r_de;

  logic [4:0]     w_fold_mask;
  logic [31:0]    w_set;
  logic [31:0]    w_vec_ok;
  logic [31:0]    w_elig;
  logic [31:0]    w_pending_next;
  logic [4:0]     w_idx;
  logic [4:0]     w_sel;
  logic           w_found;
  logic           w_unused;

  assign w_unused = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

  // Granted vector count is a power of two, so folding is a simple AND with N-1.
  always_comb begin
    w_fold_mask = 5'd31;
    case (cfg_interrupt_msi_mmenable[2:0])
      3'd0:    w_fold_mask = 5'd0;
      3'd1:    w_fold_mask = 5'd1;
      3'd2:    w_fold_mask = 5'd3;
      3'd3:    w_fold_mask = 5'd7;
      3'd4:    w_fold_mask = 5'd15;
      default: w_fold_mask = 5'd31;
    endcase
  end

  always_comb begin
    w_set = '0;
    for (int i = 0; i < IRQ_W; i++) begin
      if (irq_req[i]) w_set[5'(i) & w_fold_mask] = 1'b1;
    end
  end

  always_comb begin
    w_vec_ok = '0;
    for (int j = 0; j < 32; j++) begin
      w_vec_ok[j] = ((5'(j) & ~w_fold_mask) == 5'd0);
    end
  end

  assign w_elig = r_pending & ~r_mask & w_vec_ok & {32{cfg_interrupt_msi_enable[0]}};

  // Round-robin search begins just past the last successfully delivered vector.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 0; k < 32; k++) begin
      w_idx = r_ptr + 5'd1 + 5'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // New requests are ORed last so a set always beats the issue-cycle clear.
  always_comb begin
    w_pending_next = r_pending;
    if (r_state == ST_ISSUE) w_pending_next[r_vec] = 1'b0;
    if (r_state == ST_WAIT && cfg_interrupt_msi_fail) w_pending_next[r_vec] = 1'b1;
    w_pending_next = w_pending_next | w_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_de      <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_de      <= (w_pending_next != r_pending);
      if (cfg_interrupt_msi_mask_update) r_mask <= cfg_interrupt_msi_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_vec     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_msi_int <= '0;
    end else begin
      r_msi_int <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_vec     <= w_sel;
            r_msi_int <= 32'h1 << w_sel;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (cfg_interrupt_msi_fail) begin
            r_cnt   <= LP_CNT_INIT;
            r_state <= ST_BACKOFF;
          end else if (cfg_interrupt_msi_sent) begin
            r_ptr   <= r_vec;
            r_state <= ST_IDLE;
          end
        end
        ST_BACKOFF: begin
          if (r_cnt == '0) r_state <= ST_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign irq_pending                                   = r_pending[IRQ_W-1:0];
  assign cfg_interrupt_msi_int                         = r_msi_int;
  assign cfg_interrupt_msi_pending_status              = r_pending;
  assign cfg_interrupt_msi_pending_status_data_enable  = r_de;
  assign cfg_interrupt_msi_select                      = 2'd0;
  assign cfg_interrupt_msi_pending_status_function_num = 2'd0;
  assign cfg_interrupt_msi_attr                        = 3'd0;
  assign cfg_interrupt_msi_tph_present                 = 1'b0;
  assign cfg_interrupt_msi_tph_type                    = 2'd0;
  assign cfg_interrupt_msi_tph_st_tag                  = 8'd0;
  assign cfg_interrupt_msi_function_number             = 8'd0;

endmodule

// File: tb/tb_cndm_proto_pcie_us_msi.sv
// tb/tb_cndm_proto_pcie_us_msi.sv - self-checking bench for cndm_proto_pcie_us_msi
// Vector table, directed multi-cycle sequences, then randomized traffic against a reference model.
module tb_cndm_proto_pcie_us_msi;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] irq_req, irq_pending;
  logic [3:0]  en;
  logic [11:0] mmen;
  logic        mupd;
  logic [31:0] mdata;
  logic [1:0]  sel, fnum;
  logic [31:0] msi, pstat;
  logic        de, sent, fail;
  logic [2:0]  attr;
  logic        tph_p;
  logic [1:0]  tph_t;
  logic [7:0]  tph_tag, func;

  always #5 clk = ~clk;

  cndm_proto_pcie_us_msi #(.IRQ_W(32), .RETRY_DELAY(RD)) dut (
    .clk(clk), .rst(rst), .irq_req(irq_req), .irq_pending(irq_pending),
    .cfg_interrupt_msi_enable(en), .cfg_interrupt_msi_mmenable(mmen),
    .cfg_interrupt_msi_mask_update(mupd), .cfg_interrupt_msi_data(mdata),
    .cfg_interrupt_msi_select(sel), .cfg_interrupt_msi_int(msi),
    .cfg_interrupt_msi_pending_status(pstat),
    .cfg_interrupt_msi_pending_status_data_enable(de),
    .cfg_interrupt_msi_pending_status_function_num(fnum),
    .cfg_interrupt_msi_sent(sent), .cfg_interrupt_msi_fail(fail),
    .cfg_interrupt_msi_attr(attr), .cfg_interrupt_msi_tph_present(tph_p),
    .cfg_interrupt_msi_tph_type(tph_t), .cfg_interrupt_msi_tph_st_tag(tph_tag),
    .cfg_interrupt_msi_function_number(func)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [11:0] mm;
    logic [31:0] req;
    logic        snt;
    logic        mu;
    logic [31:0] md;
    logic [31:0] e_int;
    logic [31:0] e_pend;
    logic        e_de;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_int(input string nm, input logic [31:0] exp, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (msi == 32'h0 && n < 20);
    chk(nm, msi, exp);
  endtask

  task automatic add(input logic [11:0] mm, input logic [31:0] req, input logic snt,
                     input logic mu, input logic [31:0] md, input logic [31:0] ei,
                     input logic [31:0] ep, input logic ed);
    vec_t v;
    v.mm = mm; v.req = req; v.snt = snt; v.mu = mu; v.md = md;
    v.e_int = ei; v.e_pend = ep; v.e_de = ed;
    tbl.push_back(v);
  endtask

  function automatic int nvec(input int mm);
    return (mm >= 5) ? 32 : (1 << mm);
  endfunction

  function automatic logic [31:0] fold(input logic [31:0] r, input int mm);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < 32; i++) if (r[i]) f[i % nvec(mm)] = 1'b1;
    return f;
  endfunction

  function automatic int pick(input logic [31:0] p, input logic [31:0] m, input int ptr,
                              input int mm, output bit any);
    int idx;
    pick = 0;
    any  = 1'b0;
    for (int k = 0; k < 32; k++) begin
      idx = (ptr + 1 + k) % 32;
      if (!any && idx < nvec(mm) && p[idx] && !m[idx]) begin
        any  = 1'b1;
        pick = idx;
      end
    end
  endfunction

  int          n, exp_v, vv, mptr, rcnt, quiet, issues;
  bit          exp_any, outst, busy, issue_pend;
  logic [31:0] mp, mmask, nxt, acc, exp_int;
  int          mmv[5] = '{5, 2, 0, 7, 3};

  initial begin
    rst = 1'b1; irq_req = '0; en = 4'h1; mmen = 12'd5; mupd = 1'b0; mdata = '0;
    sent = 1'b0; fail = 1'b0;
    #2;
    chk("reset_int", msi, 32'h0);
    chk("reset_pending", irq_pending, 32'h0);
    chk("reset_consts", {22'h0, sel, fnum, attr, tph_p, tph_t, tph_tag, func, de}, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_reset_status", pstat, 32'h0);

    add(5, 32'h1, 0, 0, 0, 32'h0, 32'h1, 1);
    add(5, 32'h0, 0, 0, 0, 32'h1, 32'h1, 0);
    add(5, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1);
    add(5, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0);
    add(5, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0);
    add(5, 32'h0, 1, 0, 0, 32'h0, 32'h0, 0);
    add(5, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0);
    add(1, 32'hC, 0, 0, 0, 32'h0, 32'h3, 1);
    add(1, 32'h0, 0, 0, 0, 32'h2, 32'h3, 0);
    add(1, 32'h0, 0, 0, 0, 32'h0, 32'h1, 1);
    add(1, 32'h0, 1, 0, 0, 32'h0, 32'h1, 0);
    add(1, 32'h0, 0, 0, 0, 32'h1, 32'h1, 0);
    add(1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1);
    add(1, 32'h0, 1, 0, 0, 32'h0, 32'h0, 0);
    add(5, 32'h0, 0, 1, 2, 32'h0, 32'h0, 0);
    add(5, 32'h2, 0, 0, 0, 32'h0, 32'h2, 1);
    add(5, 32'h0, 0, 0, 0, 32'h0, 32'h2, 0);
    add(5, 32'h0, 0, 0, 0, 32'h0, 32'h2, 0);
    add(5, 32'h0, 0, 1, 0, 32'h0, 32'h2, 0);
    add(5, 32'h0, 0, 0, 0, 32'h2, 32'h2, 0);
    add(5, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1);
    add(5, 32'h0, 1, 0, 0, 32'h0, 32'h0, 0);
    add(5, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      mmen = tbl[i].mm; irq_req = tbl[i].req; sent = tbl[i].snt;
      mupd = tbl[i].mu; mdata = tbl[i].md;
      tick();
      chk($sformatf("tbl%0d_int", i), msi, tbl[i].e_int);
      chk($sformatf("tbl%0d_pend", i), irq_pending, tbl[i].e_pend);
      chk($sformatf("tbl%0d_de", i), {31'h0, de}, {31'h0, tbl[i].e_de});
    end
    irq_req = '0; sent = 1'b0; mupd = 1'b0; mmen = 12'd5;

    // round robin after vector 1 was last delivered: 2 before 0
    irq_req = 32'h5; tick(); irq_req = '0;
    wait_int("rr_first", 32'h4, n);
    tick(); sent = 1'b1; tick(); sent = 1'b0;
    wait_int("rr_second", 32'h1, n);
    tick(); sent = 1'b1; tick(); sent = 1'b0;
    chk("rr_pend_clear", irq_pending, 32'h0);

    // fail and retry, then simultaneous sent+fail treated as fail
    irq_req = 32'h8; tick(); irq_req = '0;
    wait_int("fail_issue", 32'h8, n);
    tick(); fail = 1'b1; tick(); fail = 1'b0;
    chk("fail_repend", irq_pending, 32'h8);
    wait_int("fail_retry", 32'h8, n);
    chk("fail_retry_latency", n, 5);
    tick(); sent = 1'b1; fail = 1'b1; tick(); sent = 1'b0; fail = 1'b0;
    chk("both_repend", irq_pending, 32'h8);
    wait_int("both_retry", 32'h8, n);
    chk("both_retry_latency", n, 5);
    tick(); sent = 1'b1; tick(); sent = 1'b0;
    chk("retry_pend_clear", irq_pending, 32'h0);

    // disabled MSI holds the request pending
    en = 4'h0; irq_req = 32'h1; tick(); irq_req = '0;
    acc = '0;
    for (int i = 0; i < 5; i++) begin tick(); acc |= msi; end
    chk("disabled_no_int", acc, 32'h0);
    chk("disabled_pend", irq_pending, 32'h1);
    en = 4'h1;
    wait_int("reenable_int", 32'h1, n);
    chk("reenable_latency", n, 1);
    tick(); sent = 1'b1; tick(); sent = 1'b0;

    // reset while waiting for sent
    irq_req = 32'h3; tick(); irq_req = '0;
    wait_int("rstw_issue", 32'h2, n);
    tick();
    chk("rstw_pend_before", irq_pending, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rstw_pend", irq_pending, 32'h0);
    chk("rstw_outs", msi | pstat | {31'h0, de}, 32'h0);
    tick(); tick(); rst = 1'b0;
    acc = '0;
    for (int i = 0; i < 8; i++) begin tick(); acc |= msi | irq_pending; end
    chk("rstw_quiet", acc, 32'h0);

    // randomized traffic against the reference model
    mp = '0; mmask = '0; mptr = 0; outst = 0; rcnt = 0; quiet = 0; issues = 0;
    issue_pend = 0; vv = 0;
    for (int p = 0; p < 5; p++) begin
      for (int cyc = 0; cyc < 400; cyc++) begin
        irq_req = '0; sent = 1'b0; fail = 1'b0; mupd = 1'b0;
        mmen = 12'(mmv[p]);
        if (cyc == 0) begin mupd = 1'b1; mdata = $urandom & $urandom; end
        if ($urandom_range(0, 3) == 0) irq_req = $urandom & $urandom & $urandom;
        busy = outst;
        if (outst) begin
          rcnt--;
          if (rcnt == 0) begin
            if ($urandom_range(0, 3) == 0) begin
              fail = 1'b1; sent = 1'($urandom_range(0, 1));
            end else sent = 1'b1;
          end
        end
        exp_v = pick(mp, mmask, mptr, mmv[p], exp_any);
        nxt = mp;
        if (issue_pend) nxt[vv] = 1'b0;
        if (fail) nxt[vv] = 1'b1;
        nxt |= fold(irq_req, mmv[p]);
        if (mupd) mmask = mdata;
        if (fail) begin quiet = RD + 1; outst = 0; end
        else if (sent) begin mptr = vv; outst = 0; end
        tick();
        chk("rand_pend", pstat, nxt);
        chk("rand_de", {31'h0, de}, {31'h0, (nxt != mp)});
        mp = nxt;
        issue_pend = 0;
        if (msi != 32'h0) begin
          chk("rand_int_when_busy", {31'h0, busy || quiet > 0}, 32'h0);
          exp_int = exp_any ? (32'h1 << exp_v) : 32'h0;
          chk("rand_int", msi, exp_int);
          issue_pend = 1; vv = exp_v; outst = 1; rcnt = $urandom_range(2, 5);
          issues++;
        end
        if (quiet > 0) quiet--;
      end
    end
    chk("rand_issue_count", {31'h0, issues > 50}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
